// File: rtl/sigmoid_inverse_if.sv
// Request/result bus for sigmoid_inverse: y in, x (and optional saturation flag) out.
// out_sat exists only when SIGMOID_INVERSE_SAT_EN is defined.
interface sigmoid_inverse_if;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_y;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_x;
`ifdef SIGMOID_INVERSE_SAT_EN
  logic              out_sat;

  modport master (output in_valid, in_y, out_ready,
                  input  in_ready, out_valid, out_x, out_sat);
  modport slave  (input  in_valid, in_y, out_ready,
                  output in_ready, out_valid, out_x, out_sat);
`else
  modport master (output in_valid, in_y, out_ready,
                  input  in_ready, out_valid, out_x);
  modport slave  (input  in_valid, in_y, out_ready,
                  output in_ready, out_valid, out_x);
`endif
endinterface

// File: rtl/sigmoid_inverse.sv
// Bisection inverse of the piecewise-quadratic sigmoid: smallest signed 8-bit x with f(x) >= y.
// Optional feature macro: SIGMOID_INVERSE_SAT_EN (adds out_sat flag for y > 1.0).
module sigmoid_inverse #(
  parameter int ITERS = 8
) (
  input  logic             clk,
  input  logic             rst,
  sigmoid_inverse_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       y_q, y_d;
  logic signed [8:0] lo_q, lo_d;
  logic signed [8:0] hi_q, hi_d;
  logic [3:0]        cnt_q, cnt_d;
  logic signed [7:0] out_x_q, out_x_d;
  logic              out_valid_q, out_valid_d;
  logic signed [8:0] sum;
  logic signed [8:0] mid;
`ifdef SIGMOID_INVERSE_SAT_EN
  logic              sat_q, sat_d;
`endif

  // Forward model; |x| is taken at 9 bits so that -(-128) = 128 stays positive.
  function automatic logic [15:0] fwd(input logic signed [8:0] x);
    logic [8:0]  mag;
    logic [6:0]  a;
    logic [4:0]  z;
    logic [4:0]  d;
    logic [9:0]  sq;
    logic [15:0] sh;
    mag = x[8] ? 9'(-x) : 9'(x);
    a   = (mag > 9'd64) ? 7'd64 : mag[6:0];
    z   = a[6:2];
    d   = 5'd16 - z;
    sq  = 10'(d) * 10'(d);
    sh  = 16'(sq >> 1);
    return x[8] ? sh : (16'd256 - sh);
  endfunction

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    out_x_d     = out_x_q;
    out_valid_d = out_valid_q;
`ifdef SIGMOID_INVERSE_SAT_EN
    sat_d       = sat_q;
`endif
    sum = lo_q + hi_q;
    mid = sum >>> 1;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          y_d     = bus.in_y;
          lo_d    = -9'sd128;
          hi_d    = 9'sd127;
          cnt_d   = 4'd0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        // Once the bracket has collapsed the remaining steps are no-ops.
        if (lo_q != hi_q) begin
          if (fwd(mid) >= y_q) hi_d = mid;
          else                 lo_d = mid + 9'sd1;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITERS - 1)) begin
          out_x_d     = hi_d[7:0];
          out_valid_d = 1'b1;
`ifdef SIGMOID_INVERSE_SAT_EN
          sat_d       = (y_q > 16'd256);
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      y_q         <= 16'd0;
      lo_q        <= 9'sd0;
      hi_q        <= 9'sd0;
      cnt_q       <= 4'd0;
      out_x_q     <= 8'sd0;
      out_valid_q <= 1'b0;
`ifdef SIGMOID_INVERSE_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      out_x_q     <= out_x_d;
      out_valid_q <= out_valid_d;
`ifdef SIGMOID_INVERSE_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
`ifdef SIGMOID_INVERSE_SAT_EN
  assign bus.out_sat   = sat_q;
`endif

endmodule

// File: tb/tb_sigmoid_inverse.sv
// Scoreboard bench for sigmoid_inverse: expectations from a linear-scan model of the forward curve.
module tb_sigmoid_inverse;
  localparam int ITERS = 8;

  typedef struct {
    int y;
    int x;
    int sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  sigmoid_inverse_if bus();

  sigmoid_inverse #(.ITERS(ITERS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int f_model(input int x);
    int a, z, d, sh;
    a = (x < 0) ? -x : x;
    if (a > 64) a = 64;
    z  = a / 4;
    d  = 16 - z;
    sh = (d * d) / 2;
    return (x < 0) ? sh : 256 - sh;
  endfunction

  function automatic int inv_model(input int y);
    for (int x = -128; x <= 127; x++)
      if (f_model(x) >= y) return x;
    return 127;
  endfunction

  task automatic check_value(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Caller is at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic send(input int y);
    int   w;
    exp_t e;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) begin
      check_value("in_ready_timeout", 0, 1);
      return;
    end
    e.y = y;
    e.x = inv_model(y);
    e.sat = (y > 256) ? 1 : 0;
    sb_q.push_back(e);
    bus.in_y = 16'(y);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || !bus.in_ready) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) check_value("drain_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check_value("unexpected_result", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("result y=%0d x=%0d expected=%0d", mon_e.y, $signed(bus.out_x), mon_e.x);
        check_value("out_x", int'($signed(bus.out_x)), mon_e.x);
`ifdef SIGMOID_INVERSE_SAT_EN
        check_value("out_sat", int'(bus.out_sat), mon_e.sat);
`endif
        if (mon_e.y <= 256 && $signed(bus.out_x) > -128)
          check_value("bracket",
                      int'(f_model(int'($signed(bus.out_x)) - 1) < mon_e.y &&
                           mon_e.y <= f_model(int'($signed(bus.out_x)))), 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int ylist[4];
    ylist[0] = 200; ylist[1] = 256; ylist[2] = 0; ylist[3] = 300;
    bus.in_valid  = 1'b0;
    bus.in_y      = 16'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_in_ready", int'(bus.in_ready), 1);
    check_value("rst_out_valid", int'(bus.out_valid), 0);
    check_value("rst_out_x", int'($signed(bus.out_x)), 0);
    rst = 1'b0;

    // Latency: valid rises exactly ITERS edges after accept.
    send(128);
    repeat (ITERS - 1) begin
      @(posedge clk); #1;
      check_value("lat_early", int'(bus.out_valid), 0);
    end
    @(posedge clk); #1;
    check_value("lat_valid", int'(bus.out_valid), 1);
    wait_drain();

    foreach (ylist[i]) send(ylist[i]);
    wait_drain();

    // Backpressure with an ignored request while the result is held.
    bus.out_ready = 1'b0;
    send(200);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check_value("bp_valid_seen", int'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.in_y = 16'd5;
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check_value("bp_out_x", int'($signed(bus.out_x)), inv_model(200));
      check_value("bp_in_ready", int'(bus.in_ready), 0);
      check_value("bp_out_valid", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    wait_drain();
    repeat (ITERS + 4) @(posedge clk);
    #1;
    check_value("bp_ghost", int'(bus.out_valid), 0);

    // Reset in the middle of a search.
    bus.in_y = 16'd150;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_value("midrst_out_valid", int'(bus.out_valid), 0);
    check_value("midrst_in_ready", int'(bus.in_ready), 1);
    check_value("midrst_out_x", int'($signed(bus.out_x)), 0);
    rst = 1'b0;
    send(200);
    wait_drain();

    for (int y = 0; y <= 300; y++) send(y);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
